mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter ALUOP_W, default 4, ALUOp width (>=4, codes zero-extended).
REQ-002 Parameter CNT_W, default 32, retired-instruction counter width.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 Op  input  6  opcode from datapath IR, stable from ID until return to IF.
REQ-006 Funct  input  6  funct field from IR.
REQ-007 Zero  input  1  ALU zero flag, valid in EX.
REQ-008 MemReady  input  1  data-memory completion handshake.
REQ-009 PCWrite, IRWrite, RegWrite, MemRead, MemWrite, EXTOp  output  1 each  strobes/selects.
REQ-010 ALUOp  output  ALUOP_W; NPCOp, ALUSrcA, ALUSrcB, GPRSel, WDSel  output  2 each.
REQ-011 State  output  3  current state; Illegal  output  1  unknown-instruction pulse; InstrCnt  output  CNT_W  retired count.

Function
REQ-012 States SHALL be IF, ID, EX, MEM, WB; outputs SHALL be combinational from State, Op, Funct, Zero.
REQ-013 IF: IRWrite=1, PCWrite=1, NPCOp=PLUS4; next ID.
REQ-014 ID, j/jal/jr/jalr: PCWrite=1, NPCOp=JUMP (j/jal) or REG (jr/jalr); jal: RegWrite=1, GPRSel=31, WDSel=PC; jalr: RegWrite=1, GPRSel=RD, WDSel=PC; next IF.
REQ-015 ID, unknown Op or Funct: Illegal=1 one cycle, no write strobes, next IF.
REQ-016 ID, all other decoded instructions: next EX.
REQ-017 EX: ALUOp/ALUSrcA/ALUSrcB/EXTOp per instruction (ADD 1, SUB 2, AND 3, OR 4, SLT 5, SLTU 6, NOR 7, SLL 8, SRL 9, SLLV 10, SRLV 11, LUI 12); ALUSrcA=SHAMT for sll/srl; EXTOp=1 for addi/lw/sw/andi/slti.
REQ-018 EX, beq/bne: ALUOp=SUB, PCWrite=(beq&Zero)|(bne&~Zero), NPCOp=BRANCH; next IF.
REQ-019 EX, lw/sw: next MEM; R-type and ALU-immediate: next WB.
REQ-020 MEM: lw MemRead=1, sw MemWrite=1; leave on completion: lw to WB, sw to IF.
REQ-021 WB: RegWrite=1, GPRSel=RT for I-type else RD, WDSel=MEM for lw else ALU; next IF.
REQ-022 Latency (no wait): jump 2, branch 3, sw 4, ALU 4, lw 5 cycles.
REQ-023 InstrCnt SHALL increment by 1 in the final cycle of every legal instruction, wrapping 2^CNT_W-1 to 0; no increment on Illegal.
REQ-024 No write strobe (PCWrite, IRWrite, RegWrite, MemWrite) SHALL be asserted in any state other than those listed.

Reset
REQ-025 rstn=0 at an edge: State=IF, InstrCnt=0 next cycle, irrespective of current state (including mid-MEM).
REQ-026 While rstn=0 all write strobes, MemRead and Illegal SHALL be 0; multi-bit selects 0.

Configuration
REQ-027 Macro MC_CTRL_MEM_WAIT_EN defined: MEM holds, strobe held, until MemReady=1 sampled; exit on that edge.
REQ-028 Macro undefined: MemReady ignored, MEM lasts exactly one cycle.

Structure
REQ-029 Package mc_ctrl_pkg SHALL hold state encoding, ALUOp, NPCOp, ALUSrcA/B, GPRSel, WDSel codes and opcode/funct constants.
REQ-030 Sub-module mc_decode SHALL be combinational Op/Funct to instruction-class one-hots and legality flag; mc_ctrl holds FSM and counter.

Verification
REQ-031 add (Op=0x00, Funct=0x20): State IF,ID,EX,WB; ALUOp=1 in EX; RegWrite=1, GPRSel=RD in WB; InstrCnt 0->1.
REQ-032 lw (Op=0x23), MEM_WAIT_EN, MemReady low 3 cycles: MEM lasts 4 cycles with MemRead=1; then WB with WDSel=MEM.
REQ-033 beq (Op=0x04) Zero=1: EX PCWrite=1, NPCOp=BRANCH; repeat Zero=0: PCWrite=0; both return to IF after 3 cycles.
REQ-034 jal (Op=0x03): ID RegWrite=1, GPRSel=31, WDSel=PC, NPCOp=JUMP, PCWrite=1; total 2 cycles.
REQ-035 sw (Op=0x2B), rstn=0 during MEM: MemWrite=0 next cycle, State=IF, InstrCnt=0.
REQ-036 CNT_W=4, 16 legal instructions -> InstrCnt=0; Op=0x3F -> Illegal pulse 1 cycle, InstrCnt unchanged.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, datapath
// select codes, ALU operation codes and the opcode/funct values it decodes.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_NOR  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SLLV = 4'd10;
  localparam logic [3:0] ALU_SRLV = 4'd11;
  localparam logic [3:0] ALU_LUI  = 4'd12;

  localparam logic [1:0] NPC_PLUS4  = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_REG    = 2'd3;

  localparam logic [1:0] SRCA_RS    = 2'd0;
  localparam logic [1:0] SRCA_SHAMT = 2'd1;
  localparam logic [1:0] SRCB_RT    = 2'd0;
  localparam logic [1:0] SRCB_IMM   = 2'd1;

  localparam logic [1:0] GPR_RD = 2'd0;
  localparam logic [1:0] GPR_RT = 2'd1;
  localparam logic [1:0] GPR_31 = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef struct packed {
    logic       rAlu;
    logic       iAlu;
    logic       load;
    logic       store;
    logic       beq;
    logic       bne;
    logic       j;
    logic       jal;
    logic       jr;
    logic       jalr;
    logic       shamt;
    logic       ext;
    logic       legal;
    logic [3:0] aluCode;
  } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: turns Op/Funct into class flags, the
// native ALU code for EX and a legality flag (set when any class matched).
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output dec_t       o_dec
);

  always_comb begin
    o_dec = '0;
    case (i_op)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADD:  begin o_dec.rAlu = 1'b1; o_dec.aluCode = ALU_ADD;  end
          FN_SUB:  begin o_dec.rAlu = 1'b1; o_dec.aluCode = ALU_SUB;  end
          FN_AND:  begin o_dec.rAlu = 1'b1; o_dec.aluCode = ALU_AND;  end
          FN_OR:   begin o_dec.rAlu = 1'b1; o_dec.aluCode = ALU_OR;   end
          FN_NOR:  begin o_dec.rAlu = 1'b1; o_dec.aluCode = ALU_NOR;  end
          FN_SLT:  begin o_dec.rAlu = 1'b1; o_dec.aluCode = ALU_SLT;  end
          FN_SLTU: begin o_dec.rAlu = 1'b1; o_dec.aluCode = ALU_SLTU; end
          FN_SLL:  begin o_dec.rAlu = 1'b1; o_dec.aluCode = ALU_SLL; o_dec.shamt = 1'b1; end
          FN_SRL:  begin o_dec.rAlu = 1'b1; o_dec.aluCode = ALU_SRL; o_dec.shamt = 1'b1; end
          FN_SLLV: begin o_dec.rAlu = 1'b1; o_dec.aluCode = ALU_SLLV; end
          FN_SRLV: begin o_dec.rAlu = 1'b1; o_dec.aluCode = ALU_SRLV; end
          FN_JR:   o_dec.jr   = 1'b1;
          FN_JALR: o_dec.jalr = 1'b1;
          default: ;
        endcase
      end
      OP_ADDI: begin o_dec.iAlu  = 1'b1; o_dec.aluCode = ALU_ADD; o_dec.ext = 1'b1; end
      OP_ANDI: begin o_dec.iAlu  = 1'b1; o_dec.aluCode = ALU_AND; o_dec.ext = 1'b1; end
      OP_SLTI: begin o_dec.iAlu  = 1'b1; o_dec.aluCode = ALU_SLT; o_dec.ext = 1'b1; end
      OP_ORI:  begin o_dec.iAlu  = 1'b1; o_dec.aluCode = ALU_OR;  end
      OP_LUI:  begin o_dec.iAlu  = 1'b1; o_dec.aluCode = ALU_LUI; end
      OP_LW:   begin o_dec.load  = 1'b1; o_dec.aluCode = ALU_ADD; o_dec.ext = 1'b1; end
      OP_SW:   begin o_dec.store = 1'b1; o_dec.aluCode = ALU_ADD; o_dec.ext = 1'b1; end
      OP_BEQ:  begin o_dec.beq   = 1'b1; o_dec.aluCode = ALU_SUB; end
      OP_BNE:  begin o_dec.bne   = 1'b1; o_dec.aluCode = ALU_SUB; end
      OP_J:    o_dec.j   = 1'b1;
      OP_JAL:  o_dec.jal = 1'b1;
      default: ;
    endcase
    o_dec.legal = o_dec.rAlu | o_dec.iAlu | o_dec.load | o_dec.store | o_dec.beq |
                  o_dec.bne | o_dec.j | o_dec.jal | o_dec.jr | o_dec.jalr;
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM with a retired-instruction counter.
// Define MC_CTRL_MEM_WAIT_EN to hold MEM until MemReady is sampled high.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  input  logic               MemReady,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               EXTOp,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         NPCOp,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         GPRSel,
  output logic [1:0]         WDSel,
  output logic [2:0]         State,
  output logic               Illegal,
  output logic [CNT_W-1:0]   InstrCnt
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_instrCnt;
  logic             w_retire;
  logic             w_memDone;
  logic [3:0]       w_aluCode;
  dec_t             w_dec;

  mc_decode u_decode (
    .i_op    (Op),
    .i_funct (Funct),
    .o_dec   (w_dec)
  );

`ifdef MC_CTRL_MEM_WAIT_EN
  assign w_memDone = MemReady;
`else
  logic w_unusedMemReady;
  assign w_unusedMemReady = MemReady;
  assign w_memDone        = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= S_IF;
      r_instrCnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_instrCnt <= r_instrCnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_next    = r_state;
    w_retire  = 1'b0;
    w_aluCode = ALU_NOP;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    EXTOp     = 1'b0;
    NPCOp     = NPC_PLUS4;
    ALUSrcA   = SRCA_RS;
    ALUSrcB   = SRCB_RT;
    GPRSel    = GPR_RD;
    WDSel     = WD_ALU;
    Illegal   = 1'b0;
    case (r_state)
      S_IF: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        w_next  = S_ID;
      end
      S_ID: begin
        if (!w_dec.legal) begin
          Illegal = 1'b1;
          w_next  = S_IF;
        end else if (w_dec.j | w_dec.jal | w_dec.jr | w_dec.jalr) begin
          PCWrite  = 1'b1;
          NPCOp    = (w_dec.jr | w_dec.jalr) ? NPC_REG : NPC_JUMP;
          RegWrite = w_dec.jal | w_dec.jalr;
          GPRSel   = w_dec.jal ? GPR_31 : GPR_RD;
          WDSel    = (w_dec.jal | w_dec.jalr) ? WD_PC : WD_ALU;
          w_retire = 1'b1;
          w_next   = S_IF;
        end else begin
          w_next = S_EX;
        end
      end
      S_EX: begin
        w_aluCode = w_dec.aluCode;
        ALUSrcA   = w_dec.shamt ? SRCA_SHAMT : SRCA_RS;
        ALUSrcB   = (w_dec.iAlu | w_dec.load | w_dec.store) ? SRCB_IMM : SRCB_RT;
        EXTOp     = w_dec.ext;
        if (w_dec.beq | w_dec.bne) begin
          PCWrite  = (w_dec.beq & Zero) | (w_dec.bne & ~Zero);
          NPCOp    = NPC_BRANCH;
          w_retire = 1'b1;
          w_next   = S_IF;
        end else if (w_dec.load | w_dec.store) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        MemRead  = w_dec.load;
        MemWrite = w_dec.store;
        if (w_memDone) begin
          w_retire = w_dec.store;
          w_next   = w_dec.load ? S_WB : S_IF;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        GPRSel   = (w_dec.iAlu | w_dec.load) ? GPR_RT : GPR_RD;
        WDSel    = w_dec.load ? WD_MEM : WD_ALU;
        w_retire = 1'b1;
        w_next   = S_IF;
      end
      default: w_next = S_IF;
    endcase
    // Reset is synchronous, so mask outputs until the state register has cleared.
    if (!rstn) begin
      w_aluCode = ALU_NOP;
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      EXTOp     = 1'b0;
      NPCOp     = NPC_PLUS4;
      ALUSrcA   = SRCA_RS;
      ALUSrcB   = SRCB_RT;
      GPRSel    = GPR_RD;
      WDSel     = WD_ALU;
      Illegal   = 1'b0;
    end
  end

  assign ALUOp    = ALUOP_W'(w_aluCode);
  assign State    = r_state;
  assign InstrCnt = r_instrCnt;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl (CNT_W=4 so counter wrap is reachable).
// Works with or without MC_CTRL_MEM_WAIT_EN defined.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic [5:0] Op, Funct;
  logic       Zero, MemReady;
  logic       PCWrite, IRWrite, RegWrite, MemRead, MemWrite, EXTOp, Illegal;
  logic [3:0] ALUOp;
  logic [1:0] NPCOp, ALUSrcA, ALUSrcB, GPRSel, WDSel;
  logic [2:0] State;
  logic [3:0] InstrCnt;
  logic [3:0] expCnt;
  int         tests = 0;
  int         fails = 0;

  mc_ctrl #(.ALUOP_W(4), .CNT_W(4)) dut (
    .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .EXTOp(EXTOp), .ALUOp(ALUOp), .NPCOp(NPCOp), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .GPRSel(GPRSel), .WDSel(WDSel), .State(State), .Illegal(Illegal),
    .InstrCnt(InstrCnt)
  );

  always #5 clk = ~clk;

  // Advance one cycle and land 1ns after the edge, where outputs are settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; Op = 6'h00; Funct = 6'h20; Zero = 1'b0; MemReady = 1'b1;
    step(); step();
    tests++; if (State !== 3'd0) begin fails++; $display("[TB] FAIL reset_state: got %0d want 0", State); end
    tests++; if (InstrCnt !== 4'd0) begin fails++; $display("[TB] FAIL reset_cnt: got %0d want 0", InstrCnt); end
    tests++; if ({PCWrite, IRWrite, RegWrite, MemRead, MemWrite, Illegal} !== 6'b0) begin fails++; $display("[TB] FAIL reset_strobes: got %b want 000000", {PCWrite, IRWrite, RegWrite, MemRead, MemWrite, Illegal}); end
    tests++; if ({ALUOp, NPCOp, ALUSrcA, ALUSrcB, GPRSel, WDSel} !== 14'b0) begin fails++; $display("[TB] FAIL reset_selects: got %h want 0", {ALUOp, NPCOp, ALUSrcA, ALUSrcB, GPRSel, WDSel}); end
    rstn = 1'b1; #1;
    tests++; if ({IRWrite, PCWrite, NPCOp} !== 4'b1100) begin fails++; $display("[TB] FAIL if_fetch: got %b want 1100", {IRWrite, PCWrite, NPCOp}); end
    expCnt = 4'd0;
  endtask

  task automatic test_alu();
    Op = 6'h00; Funct = 6'h20;
    step();
    tests++; if (State !== 3'd1) begin fails++; $display("[TB] FAIL add_id_state: got %0d want 1", State); end
    tests++; if ({PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0) begin fails++; $display("[TB] FAIL add_id_strobes: got %b want 0000", {PCWrite, IRWrite, RegWrite, MemWrite}); end
    step();
    tests++; if ({State, ALUOp, ALUSrcB} !== {3'd2, 4'd1, 2'd0}) begin fails++; $display("[TB] FAIL add_ex: got state %0d aluop %0d srcb %0d want 2 1 0", State, ALUOp, ALUSrcB); end
    step();
    tests++; if ({State, RegWrite, GPRSel, WDSel} !== {3'd4, 1'b1, 2'd0, 2'd0}) begin fails++; $display("[TB] FAIL add_wb: got state %0d rw %0d gpr %0d wd %0d want 4 1 0 0", State, RegWrite, GPRSel, WDSel); end
    step(); expCnt = expCnt + 4'd1;
    tests++; if ({State, InstrCnt} !== {3'd0, expCnt}) begin fails++; $display("[TB] FAIL add_retire: got state %0d cnt %0d want 0 %0d", State, InstrCnt, expCnt); end
    Op = 6'h08;
    step(); step();
    tests++; if ({ALUOp, ALUSrcB, EXTOp} !== {4'd1, 2'd1, 1'b1}) begin fails++; $display("[TB] FAIL addi_ex: got aluop %0d srcb %0d ext %0d want 1 1 1", ALUOp, ALUSrcB, EXTOp); end
    step();
    tests++; if ({State, GPRSel} !== {3'd4, 2'd1}) begin fails++; $display("[TB] FAIL addi_wb: got state %0d gpr %0d want 4 1", State, GPRSel); end
    step(); expCnt = expCnt + 4'd1;
    Op = 6'h00; Funct = 6'h00;
    step(); step();
    tests++; if ({ALUOp, ALUSrcA, EXTOp} !== {4'd8, 2'd1, 1'b0}) begin fails++; $display("[TB] FAIL sll_ex: got aluop %0d srca %0d ext %0d want 8 1 0", ALUOp, ALUSrcA, EXTOp); end
    step(); step(); expCnt = expCnt + 4'd1;
    tests++; if (InstrCnt !== expCnt) begin fails++; $display("[TB] FAIL alu_cnt: got %0d want %0d", InstrCnt, expCnt); end
  endtask

  task automatic test_branch();
    Op = 6'h04; Zero = 1'b1;
    step(); step();
    tests++; if ({State, ALUOp, PCWrite, NPCOp} !== {3'd2, 4'd2, 1'b1, 2'd1}) begin fails++; $display("[TB] FAIL beq_taken: got state %0d aluop %0d pcw %0d npc %0d want 2 2 1 1", State, ALUOp, PCWrite, NPCOp); end
    step(); expCnt = expCnt + 4'd1;
    tests++; if ({State, InstrCnt} !== {3'd0, expCnt}) begin fails++; $display("[TB] FAIL beq_return: got state %0d cnt %0d want 0 %0d", State, InstrCnt, expCnt); end
    Zero = 1'b0;
    step(); step();
    tests++; if ({PCWrite, NPCOp} !== {1'b0, 2'd1}) begin fails++; $display("[TB] FAIL beq_not_taken: got pcw %0d npc %0d want 0 1", PCWrite, NPCOp); end
    step(); expCnt = expCnt + 4'd1;
    tests++; if (State !== 3'd0) begin fails++; $display("[TB] FAIL beq_nt_return: got %0d want 0", State); end
    Op = 6'h05;
    step(); step();
    tests++; if (PCWrite !== 1'b1) begin fails++; $display("[TB] FAIL bne_taken: got %0d want 1", PCWrite); end
    step(); expCnt = expCnt + 4'd1;
  endtask

  task automatic test_jump();
    Op = 6'h03;
    step();
    tests++; if ({RegWrite, GPRSel, WDSel, NPCOp, PCWrite} !== {1'b1, 2'd2, 2'd2, 2'd2, 1'b1}) begin fails++; $display("[TB] FAIL jal_id: got rw %0d gpr %0d wd %0d npc %0d pcw %0d want 1 2 2 2 1", RegWrite, GPRSel, WDSel, NPCOp, PCWrite); end
    step(); expCnt = expCnt + 4'd1;
    tests++; if ({State, InstrCnt} !== {3'd0, expCnt}) begin fails++; $display("[TB] FAIL jal_return: got state %0d cnt %0d want 0 %0d", State, InstrCnt, expCnt); end
    Op = 6'h00; Funct = 6'h08;
    step();
    tests++; if ({RegWrite, NPCOp, PCWrite} !== {1'b0, 2'd3, 1'b1}) begin fails++; $display("[TB] FAIL jr_id: got rw %0d npc %0d pcw %0d want 0 3 1", RegWrite, NPCOp, PCWrite); end
    step(); expCnt = expCnt + 4'd1;
  endtask

  task automatic test_load();
    Op = 6'h23; MemReady = 1'b1;
    step(); step();
    tests++; if ({ALUOp, ALUSrcB, EXTOp} !== {4'd1, 2'd1, 1'b1}) begin fails++; $display("[TB] FAIL lw_ex: got aluop %0d srcb %0d ext %0d want 1 1 1", ALUOp, ALUSrcB, EXTOp); end
    step();
    MemReady = 1'b0;
`ifdef MC_CTRL_MEM_WAIT_EN
    for (int i = 0; i < 4; i++) begin
      tests++; if ({State, MemRead} !== {3'd3, 1'b1}) begin fails++; $display("[TB] FAIL lw_mem_wait%0d: got state %0d rd %0d want 3 1", i, State, MemRead); end
      if (i == 3) MemReady = 1'b1;
      step();
    end
`else
    tests++; if ({State, MemRead, MemWrite} !== {3'd3, 1'b1, 1'b0}) begin fails++; $display("[TB] FAIL lw_mem: got state %0d rd %0d wr %0d want 3 1 0", State, MemRead, MemWrite); end
    step();
`endif
    MemReady = 1'b1;
    tests++; if ({State, RegWrite, GPRSel, WDSel} !== {3'd4, 1'b1, 2'd1, 2'd1}) begin fails++; $display("[TB] FAIL lw_wb: got state %0d rw %0d gpr %0d wd %0d want 4 1 1 1", State, RegWrite, GPRSel, WDSel); end
    step(); expCnt = expCnt + 4'd1;
    tests++; if ({State, InstrCnt} !== {3'd0, expCnt}) begin fails++; $display("[TB] FAIL lw_retire: got state %0d cnt %0d want 0 %0d", State, InstrCnt, expCnt); end
  endtask

  task automatic test_store_reset();
    Op = 6'h2B; MemReady = 1'b1;
    step(); step(); step();
    tests++; if ({State, MemWrite, MemRead} !== {3'd3, 1'b1, 1'b0}) begin fails++; $display("[TB] FAIL sw_mem: got state %0d wr %0d rd %0d want 3 1 0", State, MemWrite, MemRead); end
    step(); expCnt = expCnt + 4'd1;
    tests++; if ({State, InstrCnt} !== {3'd0, expCnt}) begin fails++; $display("[TB] FAIL sw_retire: got state %0d cnt %0d want 0 %0d", State, InstrCnt, expCnt); end
    step(); step(); step();
    rstn = 1'b0;
    step();
    tests++; if ({State, InstrCnt, MemWrite, IRWrite} !== {3'd0, 4'd0, 1'b0, 1'b0}) begin fails++; $display("[TB] FAIL sw_reset: got state %0d cnt %0d wr %0d irw %0d want 0 0 0 0", State, InstrCnt, MemWrite, IRWrite); end
    rstn = 1'b1; expCnt = 4'd0;
  endtask

  task automatic test_wrap();
    Op = 6'h03;
    for (int i = 0; i < 16; i++) begin
      step(); step();
      if (i == 14) begin
        tests++; if (InstrCnt !== 4'd15) begin fails++; $display("[TB] FAIL wrap_15: got %0d want 15", InstrCnt); end
      end
    end
    tests++; if (InstrCnt !== 4'd0) begin fails++; $display("[TB] FAIL wrap_0: got %0d want 0", InstrCnt); end
  endtask

  task automatic test_illegal();
    Op = 6'h3F;
    step();
    tests++; if ({Illegal, PCWrite, IRWrite, RegWrite, MemWrite} !== 5'b10000) begin fails++; $display("[TB] FAIL illegal_id: got %b want 10000", {Illegal, PCWrite, IRWrite, RegWrite, MemWrite}); end
    step();
    tests++; if ({State, Illegal, InstrCnt} !== {3'd0, 1'b0, 4'd0}) begin fails++; $display("[TB] FAIL illegal_after: got state %0d ill %0d cnt %0d want 0 0 0", State, Illegal, InstrCnt); end
    Op = 6'h00; Funct = 6'h3F;
    step();
    tests++; if ({State, Illegal} !== {3'd1, 1'b1}) begin fails++; $display("[TB] FAIL illegal_funct: got state %0d ill %0d want 1 1", State, Illegal); end
    step();
    tests++; if ({State, InstrCnt} !== {3'd0, 4'd0}) begin fails++; $display("[TB] FAIL illegal_funct_cnt: got state %0d cnt %0d want 0 0", State, InstrCnt); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_jump();
    test_load();
    test_store_reset();
    test_wrap();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
